// File: rtl/decim_filt_tap_1.sv
// rtl/decim_filt_tap_1.sv - single-MAC polyphase decimation filter tap
// Optional rounding before the output shift: define DECIM_FILT_ROUND_EN.
module decim_filt_tap_1 #(
    parameter int DATA_WIDTH      = 6,
    parameter int TAP_COEFF_WIDTH = 6,
    parameter int DECIM_FACTOR    = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic signed [DATA_WIDTH-1:0]       in,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic signed [DATA_WIDTH-1:0]       out,
    output logic                               out_valid,
    input  logic                               out_ready,
    input  logic                               coeff_wr_en,
    input  logic [$clog2(DECIM_FACTOR)-1:0]    coeff_wr_addr,
    input  logic signed [TAP_COEFF_WIDTH-1:0]  coeff_wr_data
);
    localparam int PW  = DATA_WIDTH + TAP_COEFF_WIDTH;
    localparam int PHW = $clog2(DECIM_FACTOR);
    localparam int AW  = PW + PHW;

    localparam logic signed [TAP_COEFF_WIDTH-1:0] COEFF_RST = TAP_COEFF_WIDTH'((2 ** (TAP_COEFF_WIDTH - 1)) - 1);
    localparam logic signed [AW-1:0] OUT_MAX = AW'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [AW-1:0] OUT_MIN = AW'(-(2 ** (DATA_WIDTH - 1)));
    localparam logic [PHW-1:0]       LAST_PHASE = PHW'(DECIM_FACTOR - 1);

    logic signed [TAP_COEFF_WIDTH-1:0] coeff [DECIM_FACTOR];
    logic [PHW-1:0]                    phase;
    logic signed [AW-1:0]              acc;

    logic signed [PW-1:0]         in_ext;
    logic signed [PW-1:0]         coeff_ext;
    logic signed [PW-1:0]         product;
    logic signed [AW-1:0]         sum;
    logic signed [AW-1:0]         scaled;
    logic signed [DATA_WIDTH-1:0] sat_val;
    logic                         last;
    logic                         accept;
    logic                         addr_ok;

    assign last     = (phase == LAST_PHASE);
    // Only the block-closing sample can collide with an unconsumed result.
    assign in_ready = !(last && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign addr_ok  = ({1'b0, coeff_wr_addr} < (PHW + 1)'(DECIM_FACTOR));

    assign in_ext    = PW'(in);
    assign coeff_ext = PW'(coeff[phase]);
    assign product   = in_ext * coeff_ext;
    assign sum       = acc + AW'(product);

    always_comb begin
`ifdef DECIM_FILT_ROUND_EN
        scaled = (sum + AW'(2 ** (TAP_COEFF_WIDTH - 2))) >>> (TAP_COEFF_WIDTH - 1);
`else
        scaled = sum >>> (TAP_COEFF_WIDTH - 1);
`endif
        if (scaled > OUT_MAX) begin
            sat_val = DATA_WIDTH'(OUT_MAX);
        end else if (scaled < OUT_MIN) begin
            sat_val = DATA_WIDTH'(OUT_MIN);
        end else begin
            sat_val = DATA_WIDTH'(scaled);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase     <= '0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < DECIM_FACTOR; i++) begin
                coeff[i] <= COEFF_RST;
            end
        end else begin
            // The product above reads the pre-edge coefficient, so a same-cycle write is not seen.
            if (coeff_wr_en && addr_ok) begin
                coeff[coeff_wr_addr] <= coeff_wr_data;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (last) begin
                    out       <= sat_val;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    phase     <= '0;
                end else begin
                    acc   <= sum;
                    phase <= phase + 1'b1;
                end
            end
        end
    end
endmodule
